// File: rtl/idct_mfcc.sv
// idct_mfcc: inverse DCT (truncated, orthonormal DCT-III) that rebuilds NUM_FILTERS smoothed
// log-mel energies from NUM_MFCC cepstral coefficients with one shared multiply-accumulate.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mfcc_in               NUM_MFCC signed coefficients, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_valid / in_ready   input frame handshake (a frame is taken only in IDLE)
//   log_out               NUM_FILTERS signed energies, element n at [n*DATA_WIDTH +: DATA_WIDTH]
//   out_valid / out_ready output frame handshake (log_out is complete while out_valid is high)
//   busy                  high while the MAC is running
//   sat_pulse             one-cycle pulse after each clamped output write
//
// Optional feature: define IDCT_SAT_EN to clamp out-of-range results to the DATA_WIDTH signed
// range and report them on sat_pulse. Without it results wrap and sat_pulse stays 0.
module idct_mfcc #(
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_MFCC        = 13,
    parameter int NUM_FILTERS     = 26,
    parameter int COEFF_FRAC_BITS = 14
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MFCC*DATA_WIDTH-1:0]    mfcc_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [NUM_FILTERS*DATA_WIDTH-1:0] log_out,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              sat_pulse
);

    localparam int COEFF_WIDTH = 16;
    localparam int PROD_WIDTH  = DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_WIDTH   = PROD_WIDTH + $clog2(NUM_MFCC);
    localparam int K_WIDTH     = (NUM_MFCC > 1) ? $clog2(NUM_MFCC) : 1;
    // Row counter steps one past the last row on the final write.
    localparam int N_WIDTH     = $clog2(NUM_FILTERS + 1);
    localparam int ROM_DEPTH   = NUM_FILTERS * NUM_MFCC;
    localparam int A_WIDTH     = $clog2(ROM_DEPTH + 1);

    localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS =
        ACC_WIDTH'(64'd1 << (COEFF_FRAC_BITS - 1));
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    localparam real PI = 3.14159265358979323846;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCompute = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;

    // Basis ROM, row-major in n so the MAC walks it with a plain incrementing address.
    logic signed [COEFF_WIDTH-1:0] rom [ROM_DEPTH];

    for (genvar gn = 0; gn < NUM_FILTERS; gn++) begin : g_row
        for (genvar gk = 0; gk < NUM_MFCC; gk++) begin : g_col
            localparam real SCALE = (gk == 0) ? $sqrt(1.0 / NUM_FILTERS)
                                              : $sqrt(2.0 / NUM_FILTERS);
            localparam real VAL   = SCALE * $cos(PI * (gn + 0.5) * gk / NUM_FILTERS)
                                    * real'(64'd1 << COEFF_FRAC_BITS);
            // Round half away from zero so mirrored rows negate exactly.
            localparam int  IVAL  = (VAL >= 0.0) ? $rtoi(VAL + 0.5) : -$rtoi(0.5 - VAL);
            assign rom[gn*NUM_MFCC+gk] = COEFF_WIDTH'(IVAL);
        end
    end

    logic [1:0]                    state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  x_q [NUM_MFCC];
    logic [K_WIDTH-1:0]            k_q;
    logic [N_WIDTH-1:0]            n_q;
    logic [A_WIDTH-1:0]            addr_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic [DATA_WIDTH-1:0]         log_q [NUM_FILTERS];

    logic                          last_k, last_n;
    logic signed [DATA_WIDTH-1:0]  x_cur;
    logic signed [COEFF_WIDTH-1:0] coef;
    logic signed [PROD_WIDTH-1:0]  prod;
    logic signed [ACC_WIDTH-1:0]   sum, rnd, scaled;
    logic [DATA_WIDTH-1:0]         result;

    assign last_k = (k_q == K_WIDTH'(NUM_MFCC - 1));
    assign last_n = (n_q == N_WIDTH'(NUM_FILTERS - 1));

    assign x_cur  = x_q[k_q];
    assign coef   = rom[addr_q];
    assign prod   = x_cur * coef;
    assign sum    = acc_q + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    assign rnd    = sum + ROUND_BIAS;
    assign scaled = rnd >>> COEFF_FRAC_BITS;

`ifdef IDCT_SAT_EN
    logic sat_hit;
    logic sat_q;

    always_comb begin
        sat_hit = 1'b0;
        result  = scaled[DATA_WIDTH-1:0];
        if (scaled > OUT_MAX) begin
            result  = OUT_MAX[DATA_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (scaled < OUT_MIN) begin
            result  = OUT_MIN[DATA_WIDTH-1:0];
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= (state_q == StCompute) && last_k && sat_hit;
        end
    end

    assign sat_pulse = sat_q;
`else
    // Two's-complement wrap: only the low DATA_WIDTH bits survive.
    logic unused_scaled_hi;

    always_comb begin
        result = scaled[DATA_WIDTH-1:0];
    end

    assign unused_scaled_hi = ^{scaled[ACC_WIDTH-1:DATA_WIDTH], OUT_MAX, OUT_MIN};
    assign sat_pulse        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (in_valid) state_d = StCompute;
            StCompute: if (last_k && last_n) state_d = StDone;
            StDone:    if (out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            for (int i = 0; i < NUM_MFCC; i++) x_q[i] <= '0;
            for (int i = 0; i < NUM_FILTERS; i++) log_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_MFCC; i++) begin
                            x_q[i] <= mfcc_in[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        k_q    <= '0;
                        n_q    <= '0;
                        addr_q <= '0;
                        acc_q  <= '0;
                    end
                end
                StCompute: begin
                    addr_q <= addr_q + 1'b1;
                    if (last_k) begin
                        log_q[n_q] <= result;
                        acc_q      <= '0;
                        k_q        <= '0;
                        n_q        <= n_q + 1'b1;
                    end else begin
                        acc_q <= sum;
                        k_q   <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gn = 0; gn < NUM_FILTERS; gn++) begin : g_out
        assign log_out[gn*DATA_WIDTH +: DATA_WIDTH] = log_q[gn];
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StCompute);
    assign out_valid = (state_q == StDone);

endmodule

// File: tb/tb_idct_mfcc.sv
// Scoreboard bench for idct_mfcc: the stimulus pushes expected frames when a frame is accepted,
// a monitor pops and compares on every output handshake.
module tb_idct_mfcc;

    localparam int DW = 16;
    localparam int NM = 13;
    localparam int NF = 26;

    typedef struct packed {
        logic [NF-1:0][DW-1:0] val;
        logic [NF-1:0]         chk;
        logic                  sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [NM*DW-1:0] mfcc_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NF*DW-1:0] log_out;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             busy;
    logic             sat_pulse;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   sat_cnt = 0;
    int   frame_idx = 0;
    bit   ov_prev = 1'b0;
    exp_t sb_q[$];

    idct_mfcc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mfcc_in   (mfcc_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .log_out   (log_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .sat_pulse (sat_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NM*DW-1:0] vec_one(input int k, input int val);
        logic [NM*DW-1:0] v;
        v = '0;
        v[k*DW +: DW] = DW'(val);
        return v;
    endfunction

    function automatic logic [NM*DW-1:0] vec_all(input int val);
        logic [NM*DW-1:0] v;
        for (int k = 0; k < NM; k++) v[k*DW +: DW] = DW'(val);
        return v;
    endfunction

    // Independent basis model: orthonormal DCT-III coefficient in Q1.14.
    function automatic longint basis(input int n, input int k);
        real s;
        real c;
        s = (k == 0) ? $sqrt(1.0 / NF) : $sqrt(2.0 / NF);
        c = s * $cos(3.141592653589793 * (n + 0.5) * k / NF) * 16384.0;
        return (c >= 0.0) ? longint'($rtoi(c + 0.5)) : -longint'($rtoi(0.5 - c));
    endfunction

    function automatic exp_t model_all(input int xval);
        exp_t             e;
        longint           y;
        longint           r;
        logic signed [15:0] t;
        e = '0;
        for (int n = 0; n < NF; n++) begin
            y = 0;
            for (int k = 0; k < NM; k++) y += longint'(xval) * basis(n, k);
            r = (y + 8192) >>> 14;
`ifdef IDCT_SAT_EN
            if (r > 32767) r = 32767;
            else if (r < -32768) r = -32768;
`endif
            t = r[15:0];
            e.val[n] = t;
            e.chk[n] = 1'b1;
        end
`ifdef IDCT_SAT_EN
        e.sat = 1'b1;
`endif
        return e;
    endfunction

    // Cycle counter and acceptance timestamp (edge count after the accepting edge).
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst_n && in_valid && in_ready) acc_cyc = cyc;
    end

    // Monitor: latency on out_valid rise, full frame compare on every output handshake.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            sat_cnt = 0;
            ov_prev = 1'b0;
        end else begin
            if (sat_pulse) sat_cnt++;
            if (out_valid && !ov_prev) check($sformatf("latency_f%0d", frame_idx),
                                             cyc - acc_cyc, 338);
            ov_prev = out_valid;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    for (int n = 0; n < NF; n++) begin
                        if (e.chk[n]) begin
                            check($sformatf("f%0d_out%0d", frame_idx, n),
                                  $signed(log_out[n*DW +: DW]), $signed(e.val[n]));
                        end
                    end
                    check($sformatf("f%0d_sat_seen", frame_idx), (sat_cnt > 0) ? 1 : 0,
                          e.sat ? 1 : 0);
                end
                sat_cnt = 0;
                frame_idx++;
            end
        end
    end

    task automatic send(input logic [NM*DW-1:0] x, input exp_t e, input bit push);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        mfcc_in  = x;
        in_valid = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push && ok) sb_q.push_back(e);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    initial begin
        exp_t e201;
        exp_t ex1;
        exp_t esat;
        int   bad;

        e201 = '0;
        for (int n = 0; n < NF; n++) begin
            e201.val[n] = DW'(201);
            e201.chk[n] = 1'b1;
        end
        ex1 = '0;
        ex1.val[0]  = DW'(277);
        ex1.val[25] = DW'(-277);
        ex1.val[12] = DW'(17);
        ex1.val[13] = DW'(-17);
        ex1.chk[0]  = 1'b1;
        ex1.chk[25] = 1'b1;
        ex1.chk[12] = 1'b1;
        ex1.chk[13] = 1'b1;
        esat = model_all(32767);

        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_sat_pulse", sat_pulse, 0);
        check("reset_log_out_nonzero", (log_out == '0) ? 0 : 1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        send(vec_one(0, 1024), e201, 1'b1);
        drain();
        send(vec_one(1, 1000), ex1, 1'b1);
        drain();
        send(vec_all(32767), esat, 1'b1);
        drain();

        // Backpressure: hold out_ready low in DONE and poke in_valid.
        out_ready = 1'b0;
        send(vec_one(0, 1024), e201, 1'b1);
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("bp_reached_done", out_valid, 1);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            mfcc_in  = vec_one(1, 1000);
            in_valid = ((c % 7) == 3);
            @(negedge clk);
            check($sformatf("bp_out_valid_c%0d", c), out_valid, 1);
            check($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
            bad = 0;
            for (int n = 0; n < NF; n++) if ($signed(log_out[n*DW +: DW]) != 201) bad++;
            check($sformatf("bp_log_out_bad_c%0d", c), bad, 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_busy", busy, 0);
        send(vec_one(1, 1000), ex1, 1'b1);
        drain();

        // Reset in the middle of COMPUTE discards the frame.
        send(vec_one(0, 1024), e201, 1'b0);
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_in_ready", in_ready, 1);
        check("midreset_busy", busy, 0);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_log_out_nonzero", (log_out == '0) ? 0 : 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(vec_one(0, 1024), e201, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
